// File: rtl/gpif_wrr_sched.sv
// rtl/gpif_wrr_sched.sv - weighted round-robin GPIF-II slave-FIFO bus scheduler
module gpif_wrr_sched #(
    parameter int TurnCycles = 3,
    parameter int WgtWidth   = 4,
    parameter int TmoWidth   = 16
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  en_i,
    input  logic [3:0]            port_en_i,
    input  logic [3:0]            req_i,
    input  logic [4*WgtWidth-1:0] wgt_i,
    input  logic [TmoWidth-1:0]   tmo_lmt_i,
    output logic [3:0]            strt_o,
    input  logic [3:0]            done_i,
    output logic [1:0]            SLADDR_o,
    output logic                  SLCSn_o,
    output logic                  SLOEn_o,
    output logic [1:0]            dpoMuxSel_o,
    output logic                  tmo_o,
    output logic [1:0]            tmo_port_o,
    output logic                  busy_o
);

    localparam int TcW = (TurnCycles > 1) ? $clog2(TurnCycles) : 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ADDR,
        S_STRT,
        S_WAIT,
        S_NEXT,
        S_RLS
    } state_t;

    state_t              state_q, state_d;
    logic [1:0]          g_q, g_d;
    logic [1:0]          lst_q, lst_d;
    logic [WgtWidth-1:0] credit_q, credit_d;
    logic [TmoWidth-1:0] tcnt_q, tcnt_d;
    logic [TcW-1:0]      turn_q, turn_d;
    logic [3:0]          strt_q, strt_d;
    logic [1:0]          sladdr_q, sladdr_d;
    logic                slcsn_q, slcsn_d;
    logic                sloen_q, sloen_d;
    logic [1:0]          mux_q, mux_d;
    logic                tmo_q, tmo_d;
    logic [1:0]          tmo_port_q, tmo_port_d;
    logic                busy_q, busy_d;

    logic [3:0]          elig;
    logic                arb_hit;
    logic [1:0]          arb_g;
    logic [1:0]          arb_idx;
    logic [WgtWidth-1:0] wgt_sel;

    assign elig = req_i & port_en_i & {4{en_i}};

    // Scan from farthest to nearest so the nearest eligible port after lst wins.
    always_comb begin
        arb_hit = 1'b0;
        arb_g   = lst_q;
        arb_idx = lst_q;
        for (int k = 4; k >= 1; k--) begin
            arb_idx = lst_q + 2'(k);
            if (elig[arb_idx]) begin
                arb_hit = 1'b1;
                arb_g   = arb_idx;
            end
        end
    end

    assign wgt_sel = wgt_i[arb_g*WgtWidth +: WgtWidth];

    always_comb begin
        state_d    = state_q;
        g_d        = g_q;
        lst_d      = lst_q;
        credit_d   = credit_q;
        tcnt_d     = tcnt_q;
        turn_d     = turn_q;
        strt_d     = '0;
        sladdr_d   = sladdr_q;
        slcsn_d    = slcsn_q;
        sloen_d    = sloen_q;
        mux_d      = mux_q;
        tmo_d      = 1'b0;
        tmo_port_d = tmo_port_q;

        case (state_q)
            S_IDLE: begin
                if (arb_hit) begin
                    g_d      = arb_g;
                    lst_d    = arb_g;
                    credit_d = (wgt_sel == '0) ? WgtWidth'(1) : wgt_sel;
                    turn_d   = TcW'(TurnCycles - 1);
                    sladdr_d = arb_g;
                    slcsn_d  = 1'b0;
                    sloen_d  = (arb_g != 2'd0);
                    if (arb_g != 2'd0) mux_d = arb_g - 2'd1;
                    state_d  = S_ADDR;
                end
            end
            S_ADDR: begin
                if (turn_q == '0) begin
                    strt_d[g_q] = 1'b1;
                    state_d     = S_STRT;
                end else begin
                    turn_d = turn_q - 1'b1;
                end
            end
            S_STRT: begin
                tcnt_d  = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                tcnt_d = tcnt_q + 1'b1;
                // done takes priority over a timeout landing on the same cycle
                if (done_i[g_q]) begin
                    credit_d = credit_q - 1'b1;
                    state_d  = S_NEXT;
                end else if ((tmo_lmt_i != '0) && (tcnt_q == tmo_lmt_i - 1'b1)) begin
                    tmo_d      = 1'b1;
                    tmo_port_d = g_q;
                    credit_d   = '0;
                    slcsn_d    = 1'b1;
                    sloen_d    = 1'b1;
                    state_d    = S_RLS;
                end
            end
            S_NEXT: begin
                if ((credit_q != '0) && elig[g_q]) begin
                    strt_d[g_q] = 1'b1;
                    state_d     = S_STRT;
                end else begin
                    slcsn_d = 1'b1;
                    sloen_d = 1'b1;
                    state_d = S_RLS;
                end
            end
            S_RLS: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        busy_d = (state_d != S_IDLE);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            g_q        <= 2'd0;
            lst_q      <= 2'd3;
            credit_q   <= '0;
            tcnt_q     <= '0;
            turn_q     <= '0;
            strt_q     <= '0;
            sladdr_q   <= 2'd0;
            slcsn_q    <= 1'b1;
            sloen_q    <= 1'b1;
            mux_q      <= 2'd0;
            tmo_q      <= 1'b0;
            tmo_port_q <= 2'd0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            g_q        <= g_d;
            lst_q      <= lst_d;
            credit_q   <= credit_d;
            tcnt_q     <= tcnt_d;
            turn_q     <= turn_d;
            strt_q     <= strt_d;
            sladdr_q   <= sladdr_d;
            slcsn_q    <= slcsn_d;
            sloen_q    <= sloen_d;
            mux_q      <= mux_d;
            tmo_q      <= tmo_d;
            tmo_port_q <= tmo_port_d;
            busy_q     <= busy_d;
        end
    end

    assign strt_o      = strt_q;
    assign SLADDR_o    = sladdr_q;
    assign SLCSn_o     = slcsn_q;
    assign SLOEn_o     = sloen_q;
    assign dpoMuxSel_o = mux_q;
    assign tmo_o       = tmo_q;
    assign tmo_port_o  = tmo_port_q;
    assign busy_o      = busy_q;

endmodule

// File: tb/tb_gpif_wrr_sched.sv
// tb/tb_gpif_wrr_sched.sv - directed self-checking bench for gpif_wrr_sched
module tb_gpif_wrr_sched;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        en_i = 1'b1;
    logic [3:0]  port_en_i = 4'hF;
    logic [3:0]  req_i = 4'h0;
    logic [15:0] wgt_i = 16'h1111;
    logic [15:0] tmo_lmt_i = 16'd0;
    logic [3:0]  strt_o;
    logic [3:0]  done_i = 4'h0;
    logic [1:0]  SLADDR_o;
    logic        SLCSn_o;
    logic        SLOEn_o;
    logic [1:0]  dpoMuxSel_o;
    logic        tmo_o;
    logic [1:0]  tmo_port_o;
    logic        busy_o;

    int n_chk = 0;
    int n_pass = 0;

    gpif_wrr_sched #(.TurnCycles(3), .WgtWidth(4), .TmoWidth(16)) dut (
        .clk_i(clk_i), .rst_i(rst_i), .en_i(en_i), .port_en_i(port_en_i),
        .req_i(req_i), .wgt_i(wgt_i), .tmo_lmt_i(tmo_lmt_i), .strt_o(strt_o),
        .done_i(done_i), .SLADDR_o(SLADDR_o), .SLCSn_o(SLCSn_o), .SLOEn_o(SLOEn_o),
        .dpoMuxSel_o(dpoMuxSel_o), .tmo_o(tmo_o), .tmo_port_o(tmo_port_o), .busy_o(busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic do_reset();
        rst_i = 1'b1;
        step();
        step();
        rst_i = 1'b0;
    endtask

    task automatic send_done(input int p);
        done_i = 4'h0;
        done_i[p] = 1'b1;
        step();
        done_i = 4'h0;
    endtask

    task automatic wait_strt(input int budget, output int p, output int cyc,
                             output bit csh, output bit found);
        p = -1;
        cyc = 0;
        csh = 1'b0;
        found = 1'b0;
        while (!found && cyc < budget) begin
            step();
            cyc++;
            if (SLCSn_o) csh = 1'b1;
            if (strt_o != 4'h0) begin
                found = 1'b1;
                for (int i = 0; i < 4; i++) if (strt_o[i]) p = i;
            end
        end
    endtask

    task automatic chk_reset_outs(input string tag);
        chk({tag, "_strt"}, strt_o, 0);
        chk({tag, "_sladdr"}, SLADDR_o, 0);
        chk({tag, "_slcsn"}, SLCSn_o, 1);
        chk({tag, "_sloen"}, SLOEn_o, 1);
        chk({tag, "_mux"}, dpoMuxSel_o, 0);
        chk({tag, "_tmo"}, tmo_o, 0);
        chk({tag, "_tmo_port"}, tmo_port_o, 0);
        chk({tag, "_busy"}, busy_o, 0);
    endtask

    initial begin
        int p, cyc, last_mux;
        bit csh, found;
        int exp_t2[5];
        int exp_t3[5];
        int exp_t5[6];
        exp_t2 = '{0, 1, 2, 3, 0};
        exp_t3 = '{1, 1, 1, 2, 1};
        exp_t5 = '{0, 2, 3, 0, 2, 3};

        // Test 1: single grant timing on port 0
        do_reset();
        chk_reset_outs("rst");
        req_i = 4'b0001;
        step();
        chk("t1_addr_slcsn", SLCSn_o, 0);
        chk("t1_addr_sloen", SLOEn_o, 0);
        chk("t1_addr_sladdr", SLADDR_o, 0);
        chk("t1_addr_busy", busy_o, 1);
        chk("t1_addr_strt", strt_o, 0);
        step();
        step();
        chk("t1_turn_strt", strt_o, 0);
        step();
        chk("t1_strt", strt_o, 4'b0001);
        req_i = 4'b0000;
        step();
        chk("t1_wait_strt", strt_o, 0);
        send_done(0);
        chk("t1_next_slcsn", SLCSn_o, 0);
        step();
        chk("t1_rls_slcsn", SLCSn_o, 1);
        chk("t1_rls_sloen", SLOEn_o, 1);
        chk("t1_rls_busy", busy_o, 1);
        step();
        chk("t1_idle_busy", busy_o, 0);
        chk("t1_idle_slcsn", SLCSn_o, 1);

        // Test 2: round robin across all ports
        do_reset();
        req_i = 4'hF;
        last_mux = 0;
        for (int i = 0; i < 5; i++) begin
            wait_strt(50, p, cyc, csh, found);
            chk("t2_found", found, 1);
            chk("t2_port", p, exp_t2[i]);
            chk("t2_sladdr", SLADDR_o, exp_t2[i]);
            chk("t2_sloen", SLOEn_o, (exp_t2[i] != 0));
            if (exp_t2[i] != 0) last_mux = exp_t2[i] - 1;
            chk("t2_mux", dpoMuxSel_o, last_mux);
            step();
            step();
            send_done(exp_t2[i]);
        end

        // Test 3: weight 3 burst on port 1, weight 0 on port 2
        do_reset();
        wgt_i = 16'h1031;
        req_i = 4'b0110;
        for (int i = 0; i < 5; i++) begin
            wait_strt(50, p, cyc, csh, found);
            chk("t3_found", found, 1);
            chk("t3_port", p, exp_t3[i]);
            chk("t3_slcsn", SLCSn_o, 0);
            if (i == 1 || i == 2) begin
                chk("t3_b2b_lat", cyc, 1);
                chk("t3_cs_window", csh, 0);
            end
            if (i == 3) chk("t3_cs_release", csh, 1);
            step();
            send_done(exp_t3[i]);
        end

        // Test 4: timeout on port 3, then done on the timeout cycle
        do_reset();
        wgt_i = 16'h1111;
        tmo_lmt_i = 16'd10;
        req_i = 4'b1000;
        wait_strt(50, p, cyc, csh, found);
        chk("t4_port", p, 3);
        for (int i = 0; i < 10; i++) step();
        chk("t4_pre_tmo", tmo_o, 0);
        chk("t4_pre_slcsn", SLCSn_o, 0);
        step();
        chk("t4_tmo", tmo_o, 1);
        chk("t4_tmo_port", tmo_port_o, 3);
        chk("t4_rls_slcsn", SLCSn_o, 1);
        req_i = 4'b1011;
        step();
        chk("t4_tmo_pulse", tmo_o, 0);
        chk("t4_tmo_port_hold", tmo_port_o, 3);
        wait_strt(50, p, cyc, csh, found);
        chk("t4_next_port", p, 0);
        req_i = 4'b1000;
        step();
        send_done(0);
        wait_strt(50, p, cyc, csh, found);
        chk("t4_port_again", p, 3);
        for (int i = 0; i < 10; i++) step();
        send_done(3);
        chk("t4_done_wins_tmo", tmo_o, 0);
        chk("t4_done_next_slcsn", SLCSn_o, 0);
        step();
        chk("t4_done_rls_tmo", tmo_o, 0);
        chk("t4_done_rls_slcsn", SLCSn_o, 1);
        tmo_lmt_i = 16'd0;

        // Test 5: en_i dropped mid-burst, then masked port
        do_reset();
        wgt_i = 16'h1141;
        req_i = 4'b0010;
        wait_strt(50, p, cyc, csh, found);
        chk("t5_port", p, 1);
        en_i = 1'b0;
        step();
        send_done(1);
        step();
        chk("t5_rls_slcsn", SLCSn_o, 1);
        wait_strt(20, p, cyc, csh, found);
        chk("t5_no_strt", found, 0);
        chk("t5_idle_busy", busy_o, 0);
        do_reset();
        en_i = 1'b1;
        wgt_i = 16'h1111;
        port_en_i = 4'b1101;
        req_i = 4'hF;
        for (int i = 0; i < 6; i++) begin
            wait_strt(50, p, cyc, csh, found);
            chk("t5_mask_port", p, exp_t5[i]);
            step();
            send_done(exp_t5[i]);
        end
        port_en_i = 4'hF;

        // Test 6: reset during WAIT
        do_reset();
        req_i = 4'b1000;
        wait_strt(50, p, cyc, csh, found);
        chk("t6_port", p, 3);
        step();
        chk("t6_pre_sladdr", SLADDR_o, 3);
        chk("t6_pre_mux", dpoMuxSel_o, 2);
        rst_i = 1'b1;
        step();
        chk_reset_outs("t6_rst");
        rst_i = 1'b0;
        req_i = 4'hF;
        wait_strt(50, p, cyc, csh, found);
        chk("t6_first_port", p, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
